softmax_inv_arbiter: RTL

//  Shares one fixed-latency FP32 reciprocal unit (the softmax 1/sum LUT unit) among

---
 rtl/softmax_inv_pkg.sv | 24 ++
 rtl/softmax_inv_rr_arb.sv | 52 +++++
 rtl/softmax_inv_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/softmax_inv_pkg.sv
// softmax_inv_pkg: shared types and constants for the softmax reciprocal arbiter.
// Holds FP32 special-value constants, the per-engine request state enum and
// the tag carried alongside each operand through the reciprocal unit.
package softmax_inv_pkg;

    localparam logic [31:0] FP32_PZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_PINF  = 32'h7f80_0000;
    localparam logic [31:0] FP32_NAN   = 32'h7fc0_0000;

    // Tag id is sized for the largest supported engine count (16).
    localparam int TAG_IDW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } req_state_e;

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/softmax_inv_rr_arb.sv
// softmax_inv_rr_arb: NREQ-wide round-robin arbiter.
// Grants the first eligible requester at or after the pointer; the pointer
// moves to one past the granted requester and holds when nothing is granted.
module softmax_inv_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] eligible,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] cand;

    // Scan requesters in rotating order starting at the pointer; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_reg) + k >= NREQ) ? IDW'(int'(ptr_reg) + k - NREQ)
                                               : IDW'(int'(ptr_reg) + k);
            if ((grant == '0) && eligible[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer advances past the winner only when a grant is actually taken.
    always_comb begin
        ptr_next = ptr_reg;
        if (advance && (grant != '0)) begin
            ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register, back to requester 0 on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/softmax_inv_arbiter.sv
// softmax_inv_arbiter: shares one fixed-latency FP32 reciprocal unit among
// NREQ softmax row engines. Each engine walks IDLE -> PEND -> HOLD -> IDLE;
// a tag pipe matched to the unit latency routes each result back to its owner.
// Optional statistics counters are built when SOFTMAX_INV_ARB_STATS_EN is defined.
module softmax_inv_arbiter
    import softmax_inv_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int INV_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_fp32,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*32-1:0] rsp_fp32,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic               inv_in_valid,
    output logic [31:0]        inv_in_fp32,
    input  logic               inv_out_valid,
    input  logic [31:0]        inv_out_fp32,
    output logic               busy,
    output logic               err_sticky,
    output logic [31:0]        stat_issue,
    output logic [31:0]        stat_conflict
);

    req_state_e      state_reg  [NREQ];
    req_state_e      state_next [NREQ];
    logic [31:0]     rsp_data_reg [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] hit;
    logic [NREQ-1:0] active;
    logic [IDW-1:0]  grant_idx;
    tag_t            tag_reg [INV_LAT];
    tag_t            tag_in;
    tag_t            tag_out;
    logic            tag_any;
    logic            err_sticky_reg;

    assign tag_out = tag_reg[INV_LAT-1];

    softmax_inv_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .eligible  (eligible),
        .advance   (|grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_eng
            // An engine may be granted when idle, or when its held result is retired this cycle.
            assign eligible[gi] = rst_n & req_valid[gi] &
                                  ((state_reg[gi] == IDLE) |
                                   ((state_reg[gi] == HOLD) & rsp_ready[gi]));

            // Returning result belongs to this engine when the tag at the pipe tail names it.
            assign hit[gi] = inv_out_valid & tag_out.vld & (tag_out.id == TAG_IDW'(gi));

            // Per-engine state register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg[gi] <= IDLE;
                end else begin
                    state_reg[gi] <= state_next[gi];
                end
            end

            // Next state: grant starts an op, result moves to HOLD, retire or regrant leaves HOLD.
            always_comb begin
                state_next[gi] = state_reg[gi];
                case (state_reg[gi])
                    IDLE: if (grant[gi]) state_next[gi] = PEND;
                    PEND: if (hit[gi]) state_next[gi] = HOLD;
                    HOLD: begin
                        if (grant[gi]) begin
                            state_next[gi] = PEND;
                        end else if (rsp_ready[gi]) begin
                            state_next[gi] = IDLE;
                        end
                    end
                    default: state_next[gi] = IDLE;
                endcase
            end

            // Per-engine outputs decoded from the registered state.
            always_comb begin
                rsp_valid[gi] = (state_reg[gi] == HOLD);
                active[gi]    = (state_reg[gi] != IDLE);
            end

            // Capture the reciprocal for this engine; value persists until the next result.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rsp_data_reg[gi] <= FP32_PZERO;
                end else if (hit[gi]) begin
                    rsp_data_reg[gi] <= inv_out_fp32;
                end
            end

            assign rsp_fp32[32*gi +: 32] = rsp_data_reg[gi];
        end
    endgenerate

    assign req_ready    = grant;
    assign inv_in_valid = |grant;

    // Route the granted engine's operand to the unit; zero when idle.
    always_comb begin
        inv_in_fp32 = FP32_PZERO;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                inv_in_fp32 = req_fp32[32*r +: 32];
            end
        end
    end

    // Tag entering the pipe alongside the operand.
    always_comb begin
        tag_in     = '0;
        tag_in.vld = |grant;
        tag_in.id  = TAG_IDW'(grant_idx);
    end

    // First tag stage loads every cycle, valid only when an operand was issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_reg[0] <= '0;
        end else begin
            tag_reg[0] <= tag_in;
        end
    end

    generate
        for (gi = 1; gi < INV_LAT; gi++) begin : g_tag
            // Remaining tag stages shift in lockstep with the unit pipeline.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_reg[gi] <= '0;
                end else begin
                    tag_reg[gi] <= tag_reg[gi-1];
                end
            end
        end
    endgenerate

    // Any tag still in flight keeps the block busy.
    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < INV_LAT; k++) begin
            tag_any = tag_any | tag_reg[k].vld;
        end
    end

    assign busy = (|active) | tag_any;

    // A result without a tag, or a tag without a result, means the unit and pipe disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky_reg <= 1'b0;
        end else if (inv_out_valid ^ tag_out.vld) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_reg;

`ifdef SOFTMAX_INV_ARB_STATS_EN
    logic [31:0] stat_issue_reg;
    logic [31:0] stat_conflict_reg;

    // Free-running issue and contention counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issue_reg    <= '0;
            stat_conflict_reg <= '0;
        end else begin
            if (|grant) begin
                stat_issue_reg <= stat_issue_reg + 32'd1;
            end
            if ($countones(eligible) >= 2) begin
                stat_conflict_reg <= stat_conflict_reg + 32'd1;
            end
        end
    end

    assign stat_issue    = stat_issue_reg;
    assign stat_conflict = stat_conflict_reg;
`else
    assign stat_issue    = 32'h0;
    assign stat_conflict = 32'h0;
`endif

endmodule
